// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RV32I datapath and its controller.
// Holds datapath mux selects, ALU operations, opcodes and the immediate extender.
package riscv_mc_pkg;

    typedef enum logic [2:0] {IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                              IMM_J = 3'b011, IMM_U = 3'b100} immSrc_t;
    typedef enum logic [1:0] {SRCA_PC, SRCA_OLDPC, SRCA_A, SRCA_ZERO} srcA_t;
    typedef enum logic [1:0] {SRCB_B, SRCB_IMM, SRCB_FOUR, SRCB_ZERO} srcB_t;
    typedef enum logic [2:0] {ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                              ALU_OR = 3'b011, ALU_XOR = 3'b100} aluOp_t;
    typedef enum logic [1:0] {RES_ALUOUT, RES_MDR, RES_ALU, RES_ALUOUT_SIGN} resultSrc_t;
    typedef enum logic [1:0] {RDS_RESULT, RDS_IMM, RDS_ALUOUT, RDS_ZERO} rds_t;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [6:0] F7_SUB = 7'h20;

    function automatic logic [31:0] immExtend(input logic [31:0] i, input logic [2:0] sel);
        case (sel)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_regfile.sv
// 32-bit register file: two asynchronous read ports, one synchronous write port, x0 reads zero.
// Writes land on the clock edge; a same-cycle write is seen by readers only after that edge.
module riscv_mc_regfile #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0 && 32'(wa) < NREGS) begin
            regs[wa] <= wd;
        end
    end

    // Indices beyond NREGS read as zero so a reduced file stays well defined.
    assign rd1 = (ra1 == 5'd0 || 32'(ra1) >= NREGS) ? 32'h0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0 || 32'(ra2) >= NREGS) ? 32'h0 : regs[ra2];

endmodule

// File: rtl/riscv_mc_datapath.sv
// Multicycle RV32I datapath: architectural/pipeline registers, ALU and muxes under controller steering.
// Registers update one edge after their strobes; memory port has no stall, the controller sequences it.
module riscv_mc_datapath
    import riscv_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PcEn,
    input  logic        AdrSrc,
    input  logic        MemWrite,
    input  logic        IrWrite,
    input  logic        RegWrite,
    input  logic [2:0]  Immsrc,
    input  logic [1:0]  AluSrcA,
    input  logic [1:0]  AluSrcB,
    input  logic [2:0]  AluIn,
    input  logic [1:0]  ResultSrc,
    input  logic [1:0]  RDS,
    output logic [6:0]  Op,
    output logic [2:0]  F3,
    output logic [6:0]  F7,
    output logic        Zero,
    output logic        SignBit,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    logic [31:0] pc, oldPc, ir, mdr, aReg, bReg, aluOut;
    logic [31:0] rd1, rd2, immExt, srcA, srcB, aluResult, result, wd;

    riscv_mc_regfile #(.NREGS(NREGS)) uRegfile (
        .clk (clk),
        .rst (rst),
        .ra1 (ir[19:15]),
        .ra2 (ir[24:20]),
        .wa  (ir[11:7]),
        .we  (RegWrite),
        .wd  (wd),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    assign immExt = immExtend(ir, Immsrc);

    always_comb begin
        srcA = 32'h0;
        case (AluSrcA)
            SRCA_PC:    srcA = pc;
            SRCA_OLDPC: srcA = oldPc;
            SRCA_A:     srcA = aReg;
            default:    srcA = 32'h0;
        endcase
        srcB = 32'h0;
        case (AluSrcB)
            SRCB_B:    srcB = bReg;
            SRCB_IMM:  srcB = immExt;
            SRCB_FOUR: srcB = 32'd4;
            default:   srcB = 32'h0;
        endcase
    end

    always_comb begin
        aluResult = 32'h0;
        case (AluIn)
            ALU_ADD: aluResult = srcA + srcB;
            ALU_SUB: aluResult = srcA + ~srcB + 32'd1;
            ALU_AND: aluResult = srcA & srcB;
            ALU_OR:  aluResult = srcA | srcB;
            ALU_XOR: aluResult = srcA ^ srcB;
            default: aluResult = 32'h0;
        endcase
    end

    always_comb begin
        result = aluOut;
        case (ResultSrc)
            RES_ALUOUT: result = aluOut;
            RES_MDR:    result = mdr;
            RES_ALU:    result = aluResult;
            default:    result = {31'b0, aluOut[31]};
        endcase
        wd = result;
        case (RDS)
            RDS_RESULT: wd = result;
            RDS_IMM:    wd = immExt;
            RDS_ALUOUT: wd = aluOut;
            default:    wd = 32'h0;
        endcase
    end

    // OldPC samples the pre-update PC, so a fetch with PcEn and IrWrite keeps the instruction's own address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            oldPc  <= '0;
            ir     <= '0;
            mdr    <= '0;
            aReg   <= '0;
            bReg   <= '0;
            aluOut <= '0;
        end else begin
            if (PcEn) pc <= result;
            if (IrWrite) begin
                ir    <= mem_rdata;
                oldPc <= pc;
            end
            mdr    <= mem_rdata;
            aReg   <= rd1;
            bReg   <= rd2;
            aluOut <= aluResult;
        end
    end

    assign Op        = ir[6:0];
    assign F3        = ir[14:12];
    assign F7        = ir[31:25];
    assign Zero      = (aluResult == 32'h0);
    assign SignBit   = aluResult[31];
    assign mem_addr  = AdrSrc ? result : pc;
    assign mem_wdata = bReg;
    assign mem_we    = MemWrite;

endmodule

// File: tb/tb_riscv_mc_datapath.sv
// Bench for riscv_mc_datapath: plays controller sequences and scoreboards observed values.
module tb_riscv_mc_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        PcEn, AdrSrc, MemWrite, IrWrite, RegWrite;
    logic [2:0]  Immsrc, AluIn;
    logic [1:0]  AluSrcA, AluSrcB, ResultSrc, RDS;
    logic [6:0]  Op, F7;
    logic [2:0]  F3;
    logic        Zero, SignBit, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    riscv_mc_datapath #(.RESET_PC(32'h0000_0000), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .PcEn(PcEn), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IrWrite(IrWrite), .RegWrite(RegWrite), .Immsrc(Immsrc), .AluSrcA(AluSrcA),
        .AluSrcB(AluSrcB), .AluIn(AluIn), .ResultSrc(ResultSrc), .RDS(RDS),
        .Op(Op), .F3(F3), .F7(F7), .Zero(Zero), .SignBit(SignBit),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbQ[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbQ.push_back(e);
    endtask

    task automatic popCmp(input logic [31:0] obs);
        exp_t e;
        if (sbQ.size() == 0) begin
            nMismatched++;
            $display("FAIL sb_underflow: observed %h with nothing expected", obs);
        end else begin
            e = sbQ.pop_front();
            checkVal(e.tag, obs, e.val);
        end
    endtask

    task automatic idle();
        PcEn = 0; AdrSrc = 0; MemWrite = 0; IrWrite = 0; RegWrite = 0;
        Immsrc = 3'b000; AluSrcA = 2'b00; AluSrcB = 2'b00; AluIn = 3'b000;
        ResultSrc = 2'b00; RDS = 2'b00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Route a value onto mem_addr through the ALU/result muxes and read it back.
    task automatic peek(input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] rs,
                        input logic adr, output logic [31:0] v);
        AluSrcA = sa; AluSrcB = sb; AluIn = 3'b000; ResultSrc = rs; AdrSrc = adr;
        #1;
        v = mem_addr;
    endtask

    task automatic loadIr(input logic [31:0] instr);
        mem_rdata = instr;
        IrWrite   = 1;
        tick();
    endtask

    task automatic setReg(input logic [4:0] rd, input logic [11:0] v);
        loadIr({v, 5'd0, 3'd0, rd, 7'h13});
        RegWrite = 1; RDS = 2'b01; Immsrc = 3'b000;
        tick();
    endtask

    task automatic setPc(input logic [11:0] v);
        loadIr({v, 5'd0, 3'd0, 5'd0, 7'h13});
        PcEn = 1; AluSrcA = 2'b11; AluSrcB = 2'b01; Immsrc = 3'b000; ResultSrc = 2'b10;
        tick();
    endtask

    task automatic fetch(input logic [31:0] instr);
        mem_rdata = instr;
        PcEn = 1; IrWrite = 1; AluSrcA = 2'b00; AluSrcB = 2'b10; AluIn = 3'b000;
        ResultSrc = 2'b10; AdrSrc = 0;
        tick();
    endtask

    task automatic readReg(input logic [4:0] r, output logic [31:0] v);
        loadIr({12'd0, r, 3'd0, 5'd0, 7'h13});
        tick();
        peek(2'b10, 2'b11, 2'b10, 1'b1, v);
    endtask

    task automatic readPc(output logic [31:0] v);
        AdrSrc = 0;
        #1;
        v = mem_addr;
    endtask

    logic [31:0] v;
    logic [31:0] aluExp [8] = '{32'd12, 32'hFFFF_FFFE, 32'd5, 32'd7, 32'd2, 32'd0, 32'd0, 32'd0};
    logic [11:0] beqB   [2] = '{12'd5, 12'd7};
    logic        beqZ   [2] = '{1'b1, 1'b0};
    logic [31:0] beqPc  [2] = '{32'h18, 32'h24};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        mem_rdata = 32'h0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;

        pushExp("rst_pc", 32'h0);          readPc(v);                           popCmp(v);
        pushExp("rst_op", 32'h0);          popCmp({25'd0, Op});
        pushExp("rst_f7f3", 32'h0);        popCmp({22'd0, F7, F3});
        pushExp("rst_a", 32'h0);           peek(2'b10, 2'b11, 2'b10, 1'b1, v); popCmp(v);
        pushExp("rst_b", 32'h0);           popCmp(mem_wdata);
        pushExp("rst_aluout", 32'h0);      peek(2'b11, 2'b11, 2'b00, 1'b1, v); popCmp(v);
        rst = 0;
        tick();

        // ADD x3,x1,x2 with x1=5, x2=7
        setReg(5'd1, 12'd5);
        setReg(5'd2, 12'd7);
        pushExp("fetch_addr_pre", 32'h0);  readPc(v);                           popCmp(v);
        fetch(32'h002081B3);
        pushExp("fetch_pc", 32'h4);        readPc(v);                           popCmp(v);
        pushExp("fetch_op", 32'h33);       popCmp({25'd0, Op});
        pushExp("fetch_ir_imm", 32'h2);    Immsrc = 3'b000; peek(2'b11, 2'b01, 2'b10, 1'b1, v); popCmp(v);
        pushExp("fetch_oldpc", 32'h0);     peek(2'b01, 2'b11, 2'b10, 1'b1, v); popCmp(v);
        tick();
        pushExp("decode_a", 32'd5);        peek(2'b10, 2'b11, 2'b10, 1'b1, v); popCmp(v);
        pushExp("decode_b", 32'd7);        popCmp(mem_wdata);
        for (int op = 0; op < 8; op++) begin
            AluSrcA = 2'b10; AluSrcB = 2'b00; AluIn = 3'(op); ResultSrc = 2'b10; AdrSrc = 1;
            pushExp($sformatf("alu_op%0d", op), aluExp[op]);
            #1;
            popCmp(mem_addr);
            if (op == 1) begin pushExp("alu_sub_sign", 32'd1); popCmp({31'd0, SignBit}); end
            if (op == 5) begin pushExp("alu_undef_zero", 32'd1); popCmp({31'd0, Zero}); end
        end
        AluSrcA = 2'b10; AluSrcB = 2'b00; AluIn = 3'b000;
        tick();
        pushExp("exec_aluout", 32'd12);    peek(2'b00, 2'b00, 2'b00, 1'b1, v); popCmp(v);
        ResultSrc = 2'b00; RDS = 2'b00; RegWrite = 1;
        tick();
        pushExp("add_rf3", 32'd12);        readReg(5'd3, v);                    popCmp(v);

        // ADD x0,x1,x2 must leave x0 at zero
        loadIr(32'h00208033);
        tick();
        AluSrcA = 2'b10; AluSrcB = 2'b00; AluIn = 3'b000;
        tick();
        ResultSrc = 2'b00; RDS = 2'b00; RegWrite = 1;
        tick();
        pushExp("add_rf0", 32'd0);         readReg(5'd0, v);                    popCmp(v);
        pushExp("add_rf3_kept", 32'd12);   readReg(5'd3, v);                    popCmp(v);

        // LW x4,8(x1) with x1=0x100
        setReg(5'd1, 12'h100);
        fetch(32'h0080A203);
        tick();
        AluSrcA = 2'b10; AluSrcB = 2'b01; Immsrc = 3'b000; AluIn = 3'b000;
        tick();
        AdrSrc = 1; ResultSrc = 2'b00; mem_rdata = 32'h0000DEAD;
        pushExp("lw_mem_addr", 32'h108);
        #1;
        popCmp(mem_addr);
        tick();
        ResultSrc = 2'b01; RDS = 2'b00; RegWrite = 1;
        tick();
        pushExp("lw_rf4", 32'hDEAD);       readReg(5'd4, v);                    popCmp(v);

        // BEQ x1,x2,-8 at PC=0x20, taken then not taken
        for (int k = 0; k < 2; k++) begin
            setReg(5'd1, 12'd5);
            setReg(5'd2, beqB[k]);
            setPc(12'h020);
            fetch(32'hFE208CE3);
            Immsrc = 3'b010;
            pushExp($sformatf("beq%0d_target", k), 32'h18);
            peek(2'b01, 2'b01, 2'b10, 1'b1, v);
            popCmp(v);
            tick();
            AluSrcA = 2'b10; AluSrcB = 2'b00; AluIn = 3'b001; ResultSrc = 2'b00;
            pushExp($sformatf("beq%0d_zero", k), {31'd0, beqZ[k]});
            #1;
            popCmp({31'd0, Zero});
            PcEn = beqZ[k];
            tick();
            pushExp($sformatf("beq%0d_pc", k), beqPc[k]); readPc(v);             popCmp(v);
        end

        // JAL x1,+16 at PC=0x40
        setPc(12'h040);
        fetch(32'h010000EF);
        Immsrc = 3'b011;
        pushExp("jal_target", 32'h50);     peek(2'b01, 2'b01, 2'b10, 1'b1, v); popCmp(v);
        tick();
        PcEn = 1; ResultSrc = 2'b00; AluSrcA = 2'b01; AluSrcB = 2'b10; AluIn = 3'b000;
        tick();
        pushExp("jal_pc", 32'h50);         readPc(v);                           popCmp(v);
        RegWrite = 1; RDS = 2'b10;
        tick();
        pushExp("jal_rf1", 32'h44);        readReg(5'd1, v);                    popCmp(v);

        // LUI, S-type immediate, undefined Immsrc, store strobe
        loadIr(32'hABCDE0B7);
        RegWrite = 1; RDS = 2'b01; Immsrc = 3'b100;
        tick();
        pushExp("lui_rf1", 32'hABCDE000);  readReg(5'd1, v);                    popCmp(v);
        loadIr(32'hFE112E23);
        Immsrc = 3'b001;
        pushExp("imm_s", 32'hFFFF_FFFC);   peek(2'b11, 2'b01, 2'b10, 1'b1, v); popCmp(v);
        Immsrc = 3'b101;
        pushExp("imm_undef", 32'h0);       peek(2'b11, 2'b01, 2'b10, 1'b1, v); popCmp(v);
        MemWrite = 1;
        pushExp("sw_we", 32'd1);
        #1;
        popCmp({31'd0, mem_we});
        tick();

        // Asynchronous reset in the middle of a load
        fetch(32'h0080A203);
        tick();
        AluSrcA = 2'b10; AluSrcB = 2'b01; Immsrc = 3'b000;
        tick();
        AdrSrc = 1; ResultSrc = 2'b00; mem_rdata = 32'h0000BEEF;
        #2;
        rst = 1;
        #1;
        pushExp("midrst_pc", 32'h0);       readPc(v);                           popCmp(v);
        pushExp("midrst_we", 32'd0);       popCmp({31'd0, mem_we});
        pushExp("midrst_aluout", 32'h0);   peek(2'b11, 2'b11, 2'b00, 1'b1, v); popCmp(v);
        @(posedge clk);
        #1;
        rst = 0;
        idle();
        pushExp("midrst_rf4", 32'h0);      readReg(5'd4, v);                    popCmp(v);
        pushExp("midrst_rf1", 32'h0);      readReg(5'd1, v);                    popCmp(v);

        if (sbQ.size() != 0) begin
            nMismatched++;
            $display("FAIL sb_leftover: %0d expected values never observed", sbQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
